// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR output serializer
package fir_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int LEVEL_W_DEF    = $clog2(FIFO_DEPTH_DEF + 1);

    // Occupancy counters must represent 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fir_ser_fifo.sv
// rtl/fir_ser_fifo.sv - synchronous word FIFO with occupancy level
module fir_ser_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// rtl/fir_out_serializer.sv - FIFO-buffered byte serializer for FIR results (option: FIR_SER_SAT_EN)
module fir_out_serializer
    import fir_pkg::*;
#(
    parameter int IN_W       = 20,
    parameter int BYTES      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_W-1:0]                   in_dat,
    input  logic                              in_vld,
    output logic                              in_rdy,
    output logic [7:0]                        out_byte,
    output logic                              out_strb,
    output logic                              out_last,
    input  logic                              out_ack,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LVL_W = level_w(FIFO_DEPTH);
`ifdef FIR_SER_SAT_EN
    localparam int NB = 2;
`else
    localparam int NB = BYTES;
`endif
    localparam int SR_W  = NB * 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [IN_W-1:0] fifo_dout;

    ser_state_t       state, state_nxt;
    logic [SR_W-1:0]  shift_reg;
    logic [SR_W-1:0]  widened;
    logic [IDX_W-1:0] byte_idx;
    logic             load;
    logic             shift;
    logic             go_idle;

    // Full blocks the input even when a pop happens in the same cycle
    assign in_rdy = !full;
    assign push   = in_vld && in_rdy;

    fir_ser_fifo #(
        .W     (IN_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_dat),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

`ifdef FIR_SER_SAT_EN
    int sat_val;
    always_comb begin
        sat_val = $signed(fifo_dout);
        if (sat_val > 32767)       widened = SAT_MAX;
        else if (sat_val < -32768) widened = SAT_MIN;
        else                       widened = sat_val[15:0];
    end
`else
    always_comb begin
        widened = SR_W'($signed(fifo_dout));
    end
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ack) begin
                    if (byte_idx == LAST_IDX) begin
                        if (!empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            go_idle   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shift_reg <= widened;
                byte_idx  <= '0;
            end else if (shift) begin
                shift_reg <= shift_reg >> 8;
                byte_idx  <= byte_idx + IDX_W'(1);
            end else if (go_idle) begin
                shift_reg <= '0;
                byte_idx  <= '0;
            end
        end
    end

    assign out_strb = (state == SEND);
    assign out_byte = shift_reg[7:0];
    assign out_last = out_strb && (byte_idx == LAST_IDX);

endmodule

// File: tb/tb_fir_out_serializer.sv
// tb/tb_fir_out_serializer.sv - self-checking bench for fir_out_serializer
module tb_fir_out_serializer;

    localparam int IN_W = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IN_W-1:0] in_dat = '0;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [7:0]      out_byte;
    logic            out_strb;
    logic            out_last;
    logic            out_ack = 1'b0;
    logic [2:0]      fifo_level;

    int checks = 0;
    int failures = 0;

    fir_out_serializer #(.IN_W(IN_W), .BYTES(3), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_dat     (in_dat),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_byte   (out_byte),
        .out_strb   (out_strb),
        .out_last   (out_last),
        .out_ack    (out_ack),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0] dat;
        int              n;
        logic [7:0]      b [3];
    } vec_t;

    vec_t vecs [4];
    logic [8:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vec(input int i, input logic [IN_W-1:0] d, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        vecs[i].dat  = d;
        vecs[i].n    = n;
        vecs[i].b[0] = b0;
        vecs[i].b[1] = b1;
        vecs[i].b[2] = b2;
    endtask

    // Reference: interpret the word as a signed integer, optionally clamp, emit LSB-first bytes
    task automatic model_push(input logic [IN_W-1:0] d);
        int v;
        int n;
        v = int'($signed(d));
`ifdef FIR_SER_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        n = 2;
`else
        n = 3;
`endif
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, 8'(v & 255)});
            v = v >>> 8;
        end
    endtask

    initial begin
        logic [7:0] prev_byte;
        logic       prev_last;
        logic       prev_hold;
        logic [8:0] e;
        int         nb;
        int         guard;

`ifdef FIR_SER_SAT_EN
        nb = 2;
        set_vec(0, 20'h12345, 2, 8'hFF, 8'h7F, 8'h00);
        set_vec(1, 20'h80000, 2, 8'h00, 8'h80, 8'h00);
        set_vec(2, 20'hFFF80, 2, 8'h80, 8'hFF, 8'h00);
        set_vec(3, 20'h07FFF, 2, 8'hFF, 8'h7F, 8'h00);
`else
        nb = 3;
        set_vec(0, 20'h12345, 3, 8'h45, 8'h23, 8'h01);
        set_vec(1, 20'hFFF80, 3, 8'h80, 8'hFF, 8'hFF);
        set_vec(2, 20'h7FFFF, 3, 8'hFF, 8'hFF, 8'h07);
        set_vec(3, 20'h80000, 3, 8'h00, 8'h00, 8'hF8);
`endif

        // Reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        check("reset_strb", 32'(out_strb), 32'd0);
        check("reset_rdy", 32'(in_rdy), 32'd1);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_byte", 32'(out_byte), 32'd0);
        check("reset_last", 32'(out_last), 32'd0);

        // Table-driven single words
        for (int i = 0; i < 4; i++) begin
            out_ack = 1'b0;
            in_dat  = vecs[i].dat;
            in_vld  = 1'b1;
            step();
            in_vld = 1'b0;
            check("lat_no_strb_yet", 32'(out_strb), 32'd0);
            step();
            check("lat_strb", 32'(out_strb), 32'd1);
            out_ack = 1'b1;
            for (int k = 0; k < vecs[i].n; k++) begin
                check("vec_byte", 32'(out_byte), 32'(vecs[i].b[k]));
                check("vec_last", 32'(out_last), (k == vecs[i].n - 1) ? 32'd1 : 32'd0);
                check("vec_strb", 32'(out_strb), 32'd1);
                step();
            end
            check("vec_idle", 32'(out_strb), 32'd0);
            out_ack = 1'b0;
        end

        // Backpressure: fill FIFO plus the word in SEND, then stream gap-free
        exp_q.delete();
        out_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_dat = 20'(32'h1_1111 * (i + 1) + 32'h3);
            check("bp_rdy_before_push", 32'(in_rdy), 32'd1);
            in_vld = 1'b1;
            model_push(in_dat);
            step();
        end
        check("bp_rdy_full", 32'(in_rdy), 32'd0);
        check("bp_level_full", 32'(fifo_level), 32'd4);
        in_dat = 20'hABCDE;
        step();
        check("bp_still_full", 32'(fifo_level), 32'd4);
        in_vld  = 1'b0;
        out_ack = 1'b1;
        for (int k = 0; k < 5 * nb; k++) begin
            e = exp_q.pop_front();
            check("bp_strb", 32'(out_strb), 32'd1);
            check("bp_byte", 32'(out_byte), 32'(e[7:0]));
            check("bp_last", 32'(out_last), 32'(e[8]));
            step();
        end
        check("bp_done_idle", 32'(out_strb), 32'd0);
        check("bp_done_level", 32'(fifo_level), 32'd0);

        // Reset mid-word with a second word queued
        out_ack = 1'b0;
        in_dat  = 20'h12345;
        in_vld  = 1'b1;
        step();
        in_dat = 20'h54321;
        step();
        in_vld  = 1'b0;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("mid_strb_before", 32'(out_strb), 32'd1);
        check("mid_level_before", 32'(fifo_level), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_async_strb", 32'(out_strb), 32'd0);
        check("mid_async_level", 32'(fifo_level), 32'd0);
        check("mid_async_rdy", 32'(in_rdy), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        out_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("mid_no_bytes", 32'(out_strb), 32'd0);
        end

        // Randomized traffic against the reference queue
        exp_q.delete();
        prev_hold = 1'b0;
        prev_byte = '0;
        prev_last = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            in_vld  = ($urandom_range(0, 99) < 55);
            in_dat  = 20'($urandom);
            out_ack = ($urandom_range(0, 99) < 60);
            if (prev_hold) begin
                check("rnd_hold_strb", 32'(out_strb), 32'd1);
                check("rnd_hold_byte", 32'(out_byte), 32'(prev_byte));
                check("rnd_hold_last", 32'(out_last), 32'(prev_last));
            end
            if (in_vld && in_rdy) model_push(in_dat);
            if (out_strb && out_ack) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_byte", 32'(out_byte), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_byte", 32'(out_byte), 32'(e[7:0]));
                    check("rnd_last", 32'(out_last), 32'(e[8]));
                end
            end
            prev_hold = out_strb && !out_ack;
            prev_byte = out_byte;
            prev_last = out_last;
            step();
        end

        // Drain with ack held
        in_vld  = 1'b0;
        out_ack = 1'b1;
        guard   = 0;
        while ((exp_q.size() != 0) && (guard < 200)) begin
            if (out_strb) begin
                e = exp_q.pop_front();
                check("drain_byte", 32'(out_byte), 32'(e[7:0]));
                check("drain_last", 32'(out_last), 32'(e[8]));
            end
            step();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(out_strb), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
